meas_ctrl: RTL

Measurement sequencer for the angle datapath. It runs on the divided system clock and decides when the sensor input registers capture new samples and when the angle processor is enabled. It waits out the processor latency and accepts an angle only after several consecutive identical results. Accepted angles are latched for the BCD/seven-segment display path, then the block holds for a refresh period before the next measurement.

---
 rtl/meas_ctrl_pkg.sv | 15 +
 rtl/meas_ctrl_cycle_timer.sv | 29 ++
 rtl/meas_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/meas_ctrl_pkg.sv
// Shared types and constants for the measurement sequencer.
package meas_ctrl_pkg;

    localparam int ANGLE_W   = 9;
    localparam int ANGLE_MAX = 359;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        COMPARE,
        HOLD
    } state_t;

endpackage

// File: rtl/meas_ctrl_cycle_timer.sv
// Loadable down-counter shared by the settle and hold phases.
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (load) begin
                count <= value;
            end else if (!zero) begin
                count <= count - 1'b1;
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/meas_ctrl.sv
// Measurement sequencer: sample, settle, compare for stability, hold.
module meas_ctrl
    import meas_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_COUNT  = 3,
    parameter int MAX_TRIES     = 8,
    parameter int HOLD_CYCLES   = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cont,
    input  logic               start,
    input  logic [ANGLE_W-1:0] angle_in,
    output logic               sample_en,
    output logic               proc_en,
    output logic               busy,
    output logic [ANGLE_W-1:0] angle_out,
    output logic               angle_valid,
    output logic               range_err,
    output logic               timeout
);

    localparam int TMAX = (SETTLE_CYCLES > HOLD_CYCLES) ?
                          SETTLE_CYCLES : HOLD_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam int NW = $clog2(MAX_TRIES + 1);
    localparam int SW = $clog2(STABLE_COUNT + 1);

    state_t             state, state_d;
    logic [NW-1:0]      tries, tries_d;
    logic [SW-1:0]      stable_cnt, stable_d;
    logic [ANGLE_W-1:0] candidate, cand_d, angle_d;
    logic               valid_d, rerr_d, tout_d;
    logic               tmr_load, tmr_zero;
    logic [TW-1:0]      tmr_val;

    // Timer is loaded with N-1 so a phase lasts exactly N cycles.
    cycle_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    always_comb begin
        state_d  = state;
        tries_d  = tries;
        stable_d = stable_cnt;
        cand_d   = candidate;
        angle_d  = angle_out;
        valid_d  = 1'b0;
        rerr_d   = 1'b0;
        tout_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            IDLE: begin
                if (cont || start) begin
                    state_d  = SAMPLE;
                    tries_d  = '0;
                    stable_d = '0;
                    cand_d   = '0;
                end
            end
            SAMPLE: begin
                tries_d  = tries + 1'b1;
                tmr_load = 1'b1;
                tmr_val  = TW'(SETTLE_CYCLES - 1);
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (tmr_zero) state_d = COMPARE;
            end
            COMPARE: begin
                if (angle_in > ANGLE_W'(ANGLE_MAX)) begin
                    rerr_d   = 1'b1;
                    stable_d = '0;
                end else if (stable_cnt == '0 ||
                             angle_in != candidate) begin
                    cand_d   = angle_in;
                    stable_d = SW'(1);
                end else begin
                    stable_d = stable_cnt + 1'b1;
                end
                if (stable_d == SW'(STABLE_COUNT)) begin
                    angle_d  = cand_d;
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(HOLD_CYCLES - 1);
                end else if (tries == NW'(MAX_TRIES)) begin
                    tout_d   = 1'b1;
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(HOLD_CYCLES - 1);
                end else begin
                    state_d = SAMPLE;
                end
            end
            HOLD: begin
                if (tmr_zero) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tries       <= '0;
            stable_cnt  <= '0;
            candidate   <= '0;
            angle_out   <= '0;
            sample_en   <= 1'b0;
            proc_en     <= 1'b0;
            angle_valid <= 1'b0;
            range_err   <= 1'b0;
            timeout     <= 1'b0;
        end else if (en) begin
            state       <= state_d;
            tries       <= tries_d;
            stable_cnt  <= stable_d;
            candidate   <= cand_d;
            angle_out   <= angle_d;
            sample_en   <= (state_d == SAMPLE);
            proc_en     <= (state_d == SETTLE) ||
                           (state_d == COMPARE);
            angle_valid <= valid_d;
            range_err   <= rerr_d;
            timeout     <= tout_d;
        end else begin
            sample_en   <= 1'b0;
            proc_en     <= 1'b0;
            angle_valid <= 1'b0;
            range_err   <= 1'b0;
            timeout     <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule
